// File: rtl/sc_shiftseq.sv
// ---------------------------------------------------------------------------
// sc_shiftseq -- shift-register command sequencer
//
// Turns a falling edge on a debounced, active-low start request into a
// command sequence for an external universal shift register: an optional
// load, then a programmed number of shift-left or shift-right cycles, and a
// one-cycle done pulse. A falling edge on the active-low abort request
// cancels whatever is running. The abort issues a one-cycle clear.
//
// Optional feature macro: SC_SHIFTSEQ_PRELOAD_EN
//   defined   : preload_In port and the LOAD state exist.
//   undefined : no preload_In port, LOAD is never entered, load_OutLow = 1.
//
// Ports
//   SC_SHIFTSEQ_CLOCK_50            in  1   clock, rising edge
//   SC_SHIFTSEQ_RESET_InHigh        in  1   asynchronous reset, active-high
//   SC_SHIFTSEQ_start_InLow         in  1   start request, active-low level
//   SC_SHIFTSEQ_abort_InLow         in  1   abort request, active-low level
//   SC_SHIFTSEQ_direction_In        in  1   0 = shift left, 1 = shift right
//   SC_SHIFTSEQ_count_In            in  CW  number of shift cycles
//   SC_SHIFTSEQ_preload_In          in  1   1 = load before shifting (macro)
//   SC_SHIFTSEQ_clear_OutLow        out 1   clear command, active-low
//   SC_SHIFTSEQ_load_OutLow         out 1   load command, active-low
//   SC_SHIFTSEQ_shiftselection_Out  out 2   00 hold, 01 left, 10 right
//   SC_SHIFTSEQ_busy_Out            out 1   high whenever not IDLE
//   SC_SHIFTSEQ_done_Out            out 1   one-cycle completion pulse
//   SC_SHIFTSEQ_remaining_Out       out CW  shifts still to issue
// ---------------------------------------------------------------------------
module sc_shiftseq #(
  parameter int COUNTWIDTH = 4
) (
  input  logic                  SC_SHIFTSEQ_CLOCK_50,
  input  logic                  SC_SHIFTSEQ_RESET_InHigh,
  input  logic                  SC_SHIFTSEQ_start_InLow,
  input  logic                  SC_SHIFTSEQ_abort_InLow,
  input  logic                  SC_SHIFTSEQ_direction_In,
  input  logic [COUNTWIDTH-1:0] SC_SHIFTSEQ_count_In,
`ifdef SC_SHIFTSEQ_PRELOAD_EN
  input  logic                  SC_SHIFTSEQ_preload_In,
`endif
  output logic                  SC_SHIFTSEQ_clear_OutLow,
  output logic                  SC_SHIFTSEQ_load_OutLow,
  output logic [1:0]            SC_SHIFTSEQ_shiftselection_Out,
  output logic                  SC_SHIFTSEQ_busy_Out,
  output logic                  SC_SHIFTSEQ_done_Out,
  output logic [COUNTWIDTH-1:0] SC_SHIFTSEQ_remaining_Out
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } stateT;

  localparam logic [COUNTWIDTH-1:0] ONE_COUNT = COUNTWIDTH'(1);

  stateT                 stateReg, stateNext;
  logic                  dirReg, dirNext;
  logic [COUNTWIDTH-1:0] countReg, countNext;
  logic [COUNTWIDTH-1:0] remainingReg, remainingNext;

  // Request edge detectors: one input register plus one history register.
  logic startCurReg, startPrevReg;
  logic abortCurReg, abortPrevReg;
  // Cleared by reset; while clear the history registers follow the live
  // inputs, so a request held low through reset release never looks like
  // a fresh falling edge.
  logic armedReg;
  logic startEdge, abortEdge;

  // Registered command outputs.
  logic       clearReg;
  logic [1:0] shiftSelReg;
  logic       busyReg;
  logic       doneReg;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
  logic       loadReg;
`endif

  assign startEdge = armedReg & startPrevReg & ~startCurReg;
  assign abortEdge = armedReg & abortPrevReg & ~abortCurReg;

  // Next-state logic. Abort wins over everything, including a start edge
  // arriving in the same cycle.
  always_comb begin
    stateNext     = stateReg;
    dirNext       = dirReg;
    countNext     = countReg;
    remainingNext = remainingReg;
    if (abortEdge) begin
      stateNext     = ABORT;
      remainingNext = '0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (startEdge) begin
            dirNext   = SC_SHIFTSEQ_direction_In;
            countNext = SC_SHIFTSEQ_count_In;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
            if (SC_SHIFTSEQ_preload_In) begin
              stateNext     = LOAD;
              remainingNext = SC_SHIFTSEQ_count_In;
            end else
`endif
            if (SC_SHIFTSEQ_count_In == '0) begin
              stateNext     = DONE;
              remainingNext = '0;
            end else begin
              stateNext     = SHIFT;
              // The first shift cycle already shows what is left after it.
              remainingNext = SC_SHIFTSEQ_count_In - ONE_COUNT;
            end
          end
        end
        LOAD: begin
          if (countReg == '0) begin
            stateNext     = DONE;
            remainingNext = '0;
          end else begin
            stateNext     = SHIFT;
            remainingNext = countReg - ONE_COUNT;
          end
        end
        SHIFT: begin
          // Zero here marks the last shift cycle; never decrement past it.
          if (remainingReg == '0) begin
            stateNext = DONE;
          end else begin
            remainingNext = remainingReg - ONE_COUNT;
          end
        end
        DONE: begin
          stateNext     = IDLE;
          remainingNext = '0;
        end
        ABORT: begin
          stateNext     = IDLE;
          remainingNext = '0;
        end
        default: begin
          stateNext     = IDLE;
          remainingNext = '0;
        end
      endcase
    end
  end

  // State, edge detectors and outputs. Outputs are decoded from the state
  // being entered, so after each edge they are a pure function of stateReg.
  always_ff @(posedge SC_SHIFTSEQ_CLOCK_50 or posedge SC_SHIFTSEQ_RESET_InHigh) begin
    if (SC_SHIFTSEQ_RESET_InHigh) begin
      stateReg     <= IDLE;
      dirReg       <= 1'b0;
      countReg     <= '0;
      remainingReg <= '0;
      startCurReg  <= 1'b1;
      startPrevReg <= 1'b1;
      abortCurReg  <= 1'b1;
      abortPrevReg <= 1'b1;
      armedReg     <= 1'b0;
      clearReg     <= 1'b1;
      shiftSelReg  <= 2'b00;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
      loadReg      <= 1'b1;
`endif
    end else begin
      startCurReg  <= SC_SHIFTSEQ_start_InLow;
      abortCurReg  <= SC_SHIFTSEQ_abort_InLow;
      startPrevReg <= armedReg ? startCurReg : SC_SHIFTSEQ_start_InLow;
      abortPrevReg <= armedReg ? abortCurReg : SC_SHIFTSEQ_abort_InLow;
      armedReg     <= 1'b1;

      stateReg     <= stateNext;
      dirReg       <= dirNext;
      countReg     <= countNext;
      remainingReg <= remainingNext;

      clearReg     <= (stateNext != ABORT);
      shiftSelReg  <= (stateNext == SHIFT) ? (dirNext ? 2'b10 : 2'b01) : 2'b00;
      busyReg      <= (stateNext != IDLE);
      doneReg      <= (stateNext == DONE);
`ifdef SC_SHIFTSEQ_PRELOAD_EN
      loadReg      <= (stateNext != LOAD);
`endif
    end
  end

  assign SC_SHIFTSEQ_clear_OutLow       = clearReg;
  assign SC_SHIFTSEQ_shiftselection_Out = shiftSelReg;
  assign SC_SHIFTSEQ_busy_Out           = busyReg;
  assign SC_SHIFTSEQ_done_Out           = doneReg;
  assign SC_SHIFTSEQ_remaining_Out      = remainingReg;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
  assign SC_SHIFTSEQ_load_OutLow        = loadReg;
`else
  assign SC_SHIFTSEQ_load_OutLow        = 1'b1;
`endif

endmodule

// File: tb/tb_sc_shiftseq.sv
// ---------------------------------------------------------------------------
// tb_sc_shiftseq -- directed self-checking bench for sc_shiftseq.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point before any input changes. A request falling before edge N is
// registered at N and acted on at N+1, so the first command of a sequence
// is visible two edges after the request falls.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sc_shiftseq;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          startLow;
  logic          abortLow;
  logic          direction;
  logic [CW-1:0] count;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
  logic          preload;
`endif
  logic          clearLow;
  logic          loadLow;
  logic [1:0]    shiftSel;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  int checkCount = 0;
  int errorCount = 0;

  sc_shiftseq #(.COUNTWIDTH(CW)) dut (
    .SC_SHIFTSEQ_CLOCK_50           (clk),
    .SC_SHIFTSEQ_RESET_InHigh       (rst),
    .SC_SHIFTSEQ_start_InLow        (startLow),
    .SC_SHIFTSEQ_abort_InLow        (abortLow),
    .SC_SHIFTSEQ_direction_In       (direction),
    .SC_SHIFTSEQ_count_In           (count),
`ifdef SC_SHIFTSEQ_PRELOAD_EN
    .SC_SHIFTSEQ_preload_In         (preload),
`endif
    .SC_SHIFTSEQ_clear_OutLow       (clearLow),
    .SC_SHIFTSEQ_load_OutLow        (loadLow),
    .SC_SHIFTSEQ_shiftselection_Out (shiftSel),
    .SC_SHIFTSEQ_busy_Out           (busy),
    .SC_SHIFTSEQ_done_Out           (done),
    .SC_SHIFTSEQ_remaining_Out      (remaining)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare every output against one expected snapshot.
  task automatic expectOuts(input string tag, input logic expClr, input logic expLd,
                            input logic [1:0] expSel, input logic expBusy,
                            input logic expDone, input logic [CW-1:0] expRem);
    checkVal({tag, ".clear"},     {31'd0, clearLow}, {31'd0, expClr});
    checkVal({tag, ".load"},      {31'd0, loadLow},  {31'd0, expLd});
    checkVal({tag, ".sel"},       {30'd0, shiftSel}, {30'd0, expSel});
    checkVal({tag, ".busy"},      {31'd0, busy},     {31'd0, expBusy});
    checkVal({tag, ".done"},      {31'd0, done},     {31'd0, expDone});
    checkVal({tag, ".remaining"}, {28'd0, remaining}, {28'd0, expRem});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Falling edge on start, released again; returns once the first command
  // of the sequence is visible.
  task automatic pulseStart();
    startLow = 1'b0;
    tick();
    startLow = 1'b1;
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    startLow  = 1'b1;
    abortLow  = 1'b1;
    direction = 1'b0;
    count     = '0;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
    preload   = 1'b0;
`endif
    tick();
    tick();
    expectOuts("reset", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    rst = 1'b0;
    tick();
    tick();
    expectOuts("idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("reset and idle checked");

    // count=3, left, with a load first when the feature is built in.
    count     = 4'd3;
    direction = 1'b0;
`ifdef SC_SHIFTSEQ_PRELOAD_EN
    preload   = 1'b1;
    pulseStart();
    preload   = 1'b0;
    expectOuts("c3.load", 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 4'd3);
    tick();
`else
    pulseStart();
`endif
    expectOuts("c3.s1", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd2);
    tick();
    expectOuts("c3.s2", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd1);
    tick();
    expectOuts("c3.s3", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0);
    tick();
    expectOuts("c3.done", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0);
    tick();
    expectOuts("c3.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("count=3 left sequence checked");

    // count=0 without load: straight to done.
    count = 4'd0;
    pulseStart();
    expectOuts("c0.done", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0);
    tick();
    expectOuts("c0.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("count=0 sequence checked");

    // count=15 right, abort requested during the 5th shift.
    count     = 4'd15;
    direction = 1'b1;
    pulseStart();
    expectOuts("c15.s1", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'd14);
    for (int i = 2; i <= 5; i++) begin
      tick();
      checkVal("c15.rem", {28'd0, remaining}, 32'(15 - i));
    end
    abortLow = 1'b0;
    tick();
    expectOuts("c15.s6", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'd9);
    tick();
    expectOuts("c15.abort", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0);
    tick();
    expectOuts("c15.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    abortLow = 1'b1;
    tick();
    expectOuts("c15.held", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("count=15 abort sequence checked");

    // Full 15-shift run, no wrap of remaining.
    count     = 4'd15;
    direction = 1'b0;
    pulseStart();
    for (int i = 1; i <= 15; i++) begin
      checkVal("full.sel", {30'd0, shiftSel}, 32'd1);
      checkVal("full.rem", {28'd0, remaining}, 32'(15 - i));
      tick();
    end
    expectOuts("full.done", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0);
    tick();
    $display("count=15 full sequence checked");

    // Start and abort in the same cycle while idle.
    count    = 4'd2;
    startLow = 1'b0;
    abortLow = 1'b0;
    tick();
    startLow = 1'b1;
    abortLow = 1'b1;
    tick();
    expectOuts("both.abort", 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 4'd0);
    tick();
    expectOuts("both.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("start+abort collision checked");

    // Second start during SHIFT, inputs changed after capture.
    count     = 4'd3;
    direction = 1'b0;
    pulseStart();
    count     = 4'd9;
    direction = 1'b1;
    startLow  = 1'b0;
    tick();
    expectOuts("re.s2", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd1);
    startLow = 1'b1;
    tick();
    expectOuts("re.s3", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd0);
    tick();
    expectOuts("re.done", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0);
    tick();
    tick();
    expectOuts("re.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("restart during shift checked");

    // Start held low for 20 cycles: one sequence only.
    count     = 4'd2;
    direction = 1'b1;
    startLow  = 1'b0;
    tick();
    tick();
    expectOuts("hold.s1", 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 4'd1);
    tick();
    tick();
    expectOuts("hold.done", 1'b1, 1'b1, 2'b00, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      checkVal("hold.busy", {31'd0, busy}, 32'd0);
    end
    startLow = 1'b1;
    tick();
    $display("held start checked");

    // Asynchronous reset mid-shift, start held low through release.
    count     = 4'd5;
    direction = 1'b0;
    pulseStart();
    expectOuts("ar.s1", 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'd4);
    #1;
    rst      = 1'b1;
    startLow = 1'b0;
    #1;
    expectOuts("ar.async", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("ar.nostart", {31'd0, busy}, 32'd0);
      checkVal("ar.nodone", {31'd0, done}, 32'd0);
    end
    startLow = 1'b1;
    tick();
    tick();
    expectOuts("ar.idle", 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 4'd0);
    $display("async reset checked");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sc_shiftseq.md
SC_SHIFTSEQ -- requirements
Module: sc_shiftseq

Interface
REQ-001 The block SHALL have parameter COUNTWIDTH, default 4, giving the width of the shift-count operand.
REQ-002 The block SHALL have port SC_SHIFTSEQ_CLOCK_50, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port SC_SHIFTSEQ_RESET_InHigh, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port SC_SHIFTSEQ_start_InLow, input, 1 bit: debounced start request, active-low level.
REQ-005 The block SHALL have port SC_SHIFTSEQ_abort_InLow, input, 1 bit: debounced abort request, active-low level.
REQ-006 The block SHALL have port SC_SHIFTSEQ_direction_In, input, 1 bit: 0 = shift left, 1 = shift right.
REQ-007 The block SHALL have port SC_SHIFTSEQ_count_In, input, COUNTWIDTH bits: number of shift cycles to issue.
REQ-008 The block SHALL have port SC_SHIFTSEQ_preload_In, input, 1 bit: 1 = issue one load before shifting (present only per REQ-026).
REQ-009 The block SHALL have port SC_SHIFTSEQ_clear_OutLow, output, 1 bit: clear command to the shift register, active-low.
REQ-010 The block SHALL have port SC_SHIFTSEQ_load_OutLow, output, 1 bit: load command to the shift register, active-low.
REQ-011 The block SHALL have port SC_SHIFTSEQ_shiftselection_Out, output, 2 bits: 00 hold, 01 shift left, 10 shift right; 11 never driven.
REQ-012 The block SHALL have ports SC_SHIFTSEQ_busy_Out (1 bit, high outside IDLE), SC_SHIFTSEQ_done_Out (1 bit, one-cycle completion pulse) and SC_SHIFTSEQ_remaining_Out (COUNTWIDTH bits, shifts still to issue), all outputs.

Function
REQ-013 The block SHALL register start and abort inputs once and detect a request as previous sample 1, current sample 0 (falling edge); a held-low level SHALL produce one request only.
REQ-014 The block SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, ABORT; all outputs SHALL be Moore outputs decoded from registered state only.
REQ-015 In IDLE, on a start edge, the block SHALL capture count_In, direction_In and preload_In, and transition to LOAD if preload=1, else to DONE if count=0, else to SHIFT.
REQ-016 LOAD SHALL last exactly one cycle with load_OutLow=0, then go to DONE if captured count=0, else to SHIFT.
REQ-017 SHIFT SHALL drive shiftselection_Out=01 (dir 0) or 10 (dir 1) for exactly count cycles, decrementing remaining_Out each cycle; it SHALL go to DONE in the cycle remaining_Out reaches 0.
REQ-018 DONE SHALL last one cycle with done_Out=1, then return to IDLE.
REQ-019 An abort edge in any state SHALL go to ABORT next cycle; ABORT SHALL last one cycle with clear_OutLow=0, done_Out=0, remaining_Out=0, then go to IDLE.
REQ-020 An abort edge SHALL take priority over a simultaneous start edge; the start edge SHALL be discarded.
REQ-021 Start edges outside IDLE SHALL be ignored and not queued; inputs changing after capture SHALL not affect a running sequence.
REQ-022 Outside their stated states, the block SHALL hold clear_OutLow=1, load_OutLow=1, shiftselection_Out=00 and done_Out=0; two commands SHALL never be asserted in the same cycle.
REQ-023 Count = 2^COUNTWIDTH-1 (15 at default) SHALL issue exactly 15 shifts with no wrap-around of remaining_Out.

Reset
REQ-024 On RESET_InHigh=1, the block SHALL immediately and asynchronously enter IDLE with clear_OutLow=1, load_OutLow=1, shiftselection_Out=00, busy_Out=0, done_Out=0, remaining_Out=0, and both edge-detect samples set to 1.
REQ-025 On reset mid-sequence, the block SHALL abandon the sequence with no done pulse, and no request SHALL be detected while start or abort are held low through reset release.

Configuration
REQ-026 With macro SC_SHIFTSEQ_PRELOAD_EN defined, preload_In and the LOAD state SHALL exist per REQ-015/016; undefined, preload_In SHALL be absent, LOAD never entered, and load_OutLow tied to 1.

Verification
REQ-027 Scenario: reset, count=3, dir=0, preload=1, start edge -> load_OutLow low 1 cycle, shiftselection 01 for 3 cycles (remaining 2,1,0), done pulse 1 cycle, busy falls.
REQ-028 Scenario: count=0, preload=0, start edge -> no shift, no load, done pulse on next cycle.
REQ-029 Scenario: count=15, dir=1, abort edge after 5th shift -> clear_OutLow low 1 cycle, no done, IDLE with remaining 0.
REQ-030 Scenario: start and abort edges in same cycle while IDLE -> ABORT only, no shift issued.
REQ-031 Scenario: second start edge during SHIFT, and start held low 20 cycles -> exactly one sequence executed.
REQ-032 Scenario: RESET_InHigh pulsed asynchronously during SHIFT -> all outputs at reset values before next clock edge.
